onehot_write_port: RTL
======================

// Module: onehot_write_port
// PURPOSE
//  Write-side counterpart of the one-hot decoded register read path.
//  - Accepts single write requests over a valid/ready handshake.
//  - Registers the binary address as a one-hot select, then commits the data into exactly one
//    of NUM_REGS data registers, using an AND-mask with the one-hot select.
//  - Sits between the bus/test driver and the register bank; the register bank contents feed
//    the existing read path through regs_o.
// PARAMETERS
//  NUM_REGS  4  number of data registers (>=2, need not be a power of two)
//  DATA_W    8  width of each data register in bits
//  ADDR_W    $clog2(NUM_REGS)  address width (derived, not overridden)
// PORTS
//  clk_i         in   1                  single clock, rising edge
//  rst_i         in   1                  asynchronous, active-low reset
//  wr_valid_i    in   1                  write request valid
//  wr_ready_o    out  1                  block can accept a request
//  wr_addr_i     in   ADDR_W             binary register index
//  wr_data_i     in   DATA_W             write data
//  wr_ack_o      out  1                  1-cycle pulse: write committed
//  wr_err_o      out  1                  1-cycle pulse: address >= NUM_REGS, nothing written
//  oh_wr_addr_o  out  NUM_REGS           registered one-hot select (0 when idle)
//  regs_o        out  NUM_REGS*DATA_W    register bank; reg k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Clock and reset: one clock, clk_i. rst_i is asynchronous and active-low.
//  - Reset (rst_i=0, takes effect immediately):
//    - state=IDLE, wr_ready_o=1, wr_ack_o=0, wr_err_o=0.
//    - oh_wr_addr_o=0, regs_o=0, internal addr/data latches=0.
//  - FSM: IDLE -> DECODE -> COMMIT -> IDLE. No other transitions exist.
//    - IDLE: wr_ready_o=1.
//      - On an edge with wr_valid_i & wr_ready_o: latch wr_addr_i and wr_data_i, go to DECODE.
//      - Otherwise stay in IDLE.
//    - DECODE: wr_ready_o=0.
//      - oh_wr_addr_o <= (addr<NUM_REGS) ? (1<<addr) : 0, then go to COMMIT.
//    - COMMIT: wr_ready_o=0.
//      - On the edge: reg[k] <= data for each k with oh_wr_addr_o[k]=1.
//      - On the same edge: wr_ack_o<=1 if oh_wr_addr_o!=0, else wr_err_o<=1.
//      - On the same edge: oh_wr_addr_o<=0 and state goes to IDLE.
//  - Outputs are registered. wr_ready_o is decoded from state only, with no comb path from
//    wr_valid_i.
//  - Latency:
//    - Accept edge E0, decode E1, commit E2.
//    - regs_o shows new data, and ack/err is high, in the cycle after E2.
//    - wr_ready_o is high again in that same cycle.
//    - Throughput is 1 write per 3 cycles.
//  - Pulses: wr_ack_o and wr_err_o are high for exactly 1 cycle and are never high together.
//  - Select: oh_wr_addr_o has at most one bit set at any time.
//  - Inputs ignored while busy: wr_addr_i and wr_data_i changes after E0 have no effect.
//    wr_valid_i is ignored while wr_ready_o=0.
//  - Back-to-back: a request presented in the ack cycle is accepted on that edge (ready=1).
//    Its ack follows 3 cycles after the previous ack.
//  - Unwritten registers hold their value, including on an erroring write.
//  - Rewriting the same register with the same data still produces an ack.
//  - Reset mid-operation (DECODE or COMMIT): the pending write is dropped.
//    - No ack/err pulse.
//    - regs_o=0.
// TESTING
//  - Reset: hold rst_i=0 -> all outputs 0 except wr_ready_o=1.
//    Deassert rst_i -> no spurious ack/err.
//  - Single write addr=2, data=8'hA5:
//    - wr_ready_o low for 2 cycles.
//    - oh_wr_addr_o=4'b0100 during COMMIT.
//    - Then reg2=8'hA5, wr_ack_o pulses once, other regs stay 0.
//  - Back-to-back writes (0,8'h11), (3,8'h33), with valid held high:
//    - acks 3 cycles apart.
//    - reg0=8'h11, reg3=8'h33.
//  - NUM_REGS=3, write addr=3, data=8'hFF:
//    - wr_err_o pulses once, no ack, oh_wr_addr_o stays 0.
//    - regs_o unchanged.
//  - Write addr=1, data=8'h5A; change wr_addr_i/wr_data_i after E0:
//    - only reg1=8'h5A is written.
//  - Write addr=1, data=8'h77; assert rst_i=0 while in COMMIT before the edge:
//    - reg1=0, no ack.
//    - Write after reset completes normally.

Source files
------------

// File: rtl/onehot_write_port.sv
// rtl/onehot_write_port.sv - single-request write port committing through a registered one-hot select
//
// Accepts one write at a time over a valid/ready handshake, registers the
// binary address as a one-hot select, then commits the data into exactly one
// register of the bank using an AND-mask built from that select.
//
// Ports:
//   clk_i         in   1                  clock, rising edge
//   rst_i         in   1                  asynchronous active-low reset
//   wr_valid_i    in   1                  write request valid
//   wr_ready_o    out  1                  high when a request can be accepted
//   wr_addr_i     in   ADDR_W             binary register index
//   wr_data_i     in   DATA_W             write data
//   wr_ack_o      out  1                  1-cycle pulse: write committed
//   wr_err_o      out  1                  1-cycle pulse: address out of range, nothing written
//   oh_wr_addr_o  out  NUM_REGS           registered one-hot select, zero when idle
//   regs_o        out  NUM_REGS*DATA_W    register bank, reg k at [k*DATA_W +: DATA_W]

module onehot_write_port #(
    parameter int  NUM_REGS = 4,
    parameter int  DATA_W   = 8,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic                         wr_ack_o,
    output logic                         wr_err_o,
    output logic [NUM_REGS-1:0]          oh_wr_addr_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                       state;
    state_t                       next_state;

    logic [ADDR_W-1:0]            addr_q;
    logic [DATA_W-1:0]            data_q;
    logic [NUM_REGS-1:0]          oh_q;
    logic [NUM_REGS-1:0]          oh_dec;
    logic                         ack_q;
    logic                         err_q;
    logic [NUM_REGS*DATA_W-1:0]   regs_q;
    logic [NUM_REGS*DATA_W-1:0]   regs_next;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ready depends on state only so there is no
    // combinational path from wr_valid_i to wr_ready_o.
    always_comb begin
        next_state = state;
        wr_ready_o = 1'b0;
        case (state)
            S_IDLE: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = S_COMMIT;
            end
            S_COMMIT: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Address decode: only indices below NUM_REGS have a select bit, so an
    // out-of-range address naturally decodes to all zeros.
    always_comb begin
        oh_dec = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            oh_dec[k] = (addr_q == ADDR_W'(k));
        end
    end

    // Masked update: each register either keeps its value or takes data_q,
    // chosen by its own select bit.
    always_comb begin
        regs_next = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_next[k*DATA_W +: DATA_W] =
                (regs_q[k*DATA_W +: DATA_W] & ~{DATA_W{oh_q[k]}}) |
                (data_q & {DATA_W{oh_q[k]}});
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= '0;
            data_q <= '0;
            oh_q   <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            regs_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_valid_i) begin
                        addr_q <= wr_addr_i;
                        data_q <= wr_data_i;
                    end
                end
                S_DECODE: begin
                    oh_q <= oh_dec;
                end
                S_COMMIT: begin
                    regs_q <= regs_next;
                    ack_q  <= |oh_q;
                    err_q  <= ~|oh_q;
                    oh_q   <= '0;
                end
                default: begin
                    oh_q <= '0;
                end
            endcase
        end
    end

    assign wr_ack_o     = ack_q;
    assign wr_err_o     = err_q;
    assign oh_wr_addr_o = oh_q;
    assign regs_o       = regs_q;

endmodule
